// File: rtl/input_debouncer.sv
// Synchronizes a raw asynchronous level and debounces it into a clean level,
// with one-cycle rise/fall pulses and a saturating count of aborted qualifications.
module input_debouncer #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned GLITCH_W        = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                raw_i,
   input  logic                clr_glitch_i,
   output logic                level_o,
   output logic                rise_o,
   output logic                fall_o,
   output logic                busy_o,
   output logic [GLITCH_W-1:0] glitch_cnt_o
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
   localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      CHK_HIGH    = 2'd1,
      STABLE_HIGH = 2'd2,
      CHK_LOW     = 2'd3
   } state_t;

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   glitch_evt_c;

   // Metastability chain; only the last stage is used by the debouncer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // A qualification is aborted when the sample returns to the current stable level.
   assign glitch_evt_c = ((state == CHK_HIGH) && !s) || ((state == CHK_LOW) && s);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= STABLE_LOW;
         cnt     <= '0;
         level_o <= 1'b0;
         rise_o  <= 1'b0;
         fall_o  <= 1'b0;
      end else begin
         rise_o <= 1'b0;
         fall_o <= 1'b0;
         unique case (state)
            STABLE_LOW: begin
               if (s) begin
                  state <= CHK_HIGH;
                  cnt   <= CNT_ONE;
               end else begin
                  cnt <= '0;
               end
            end
            CHK_HIGH: begin
               if (!s) begin
                  state <= STABLE_LOW;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state   <= STABLE_HIGH;
                  level_o <= 1'b1;
                  rise_o  <= 1'b1;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            STABLE_HIGH: begin
               if (!s) begin
                  state <= CHK_LOW;
                  cnt   <= CNT_ONE;
               end else begin
                  cnt <= '0;
               end
            end
            CHK_LOW: begin
               if (s) begin
                  state <= STABLE_HIGH;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state   <= STABLE_LOW;
                  level_o <= 1'b0;
                  fall_o  <= 1'b1;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= STABLE_LOW;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign busy_o = (state == CHK_HIGH) || (state == CHK_LOW);

   // Saturating glitch counter; a clear takes priority over a same-cycle event.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         glitch_cnt_o <= '0;
      end else if (clr_glitch_i) begin
         glitch_cnt_o <= '0;
      end else if (glitch_evt_c && (glitch_cnt_o != GLITCH_MAX)) begin
         glitch_cnt_o <= glitch_cnt_o + GLITCH_W'(1);
      end
   end

endmodule

// File: tb/tb_input_debouncer.sv
// Randomized and directed bench for input_debouncer against a run-length model
// (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, GLITCH_W=2).
module tb_input_debouncer;

   localparam int unsigned SYNC = 2;
   localparam int unsigned D    = 4;
   localparam int unsigned GW   = 2;
   localparam int          GMAX = (1 << GW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          raw_i;
   logic          clr_glitch_i;
   logic          level_o;
   logic          rise_o;
   logic          fall_o;
   logic          busy_o;
   logic [GW-1:0] glitch_cnt_o;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: raw delayed by SYNC edges, accepted level, length of the
   // current run of samples that disagree with it, and the glitch tally.
   logic [SYNC-1:0] m_pipe;
   logic            m_level, m_rise, m_fall;
   int              m_run, m_glitch;

   input_debouncer #(
      .SYNC_STAGES    (SYNC),
      .DEBOUNCE_CYCLES(D),
      .GLITCH_W       (GW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .raw_i       (raw_i),
      .clr_glitch_i(clr_glitch_i),
      .level_o     (level_o),
      .rise_o      (rise_o),
      .fall_o      (fall_o),
      .busy_o      (busy_o),
      .glitch_cnt_o(glitch_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pipe   = '0;
      m_level  = 1'b0;
      m_rise   = 1'b0;
      m_fall   = 1'b0;
      m_run    = 0;
      m_glitch = 0;
   endtask

   function automatic bit glitch_next();
      return (m_run > 0) && (m_pipe[SYNC-1] == m_level);
   endfunction

   task automatic model_edge(input logic r, input logic c);
      logic s;
      bit   gl;
      s      = m_pipe[SYNC-1];
      gl     = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s != m_level) begin
         m_run++;
         if (m_run == D) begin
            m_level = s;
            m_rise  = s;
            m_fall  = !s;
            m_run   = 0;
         end
      end else begin
         gl    = (m_run > 0);
         m_run = 0;
      end
      if (c) m_glitch = 0;
      else if (gl && m_glitch < GMAX) m_glitch++;
      m_pipe = {m_pipe[SYNC-2:0], r};
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".level"}, 32'(level_o), 32'(m_level));
      check({tag, ".rise"}, 32'(rise_o), 32'(m_rise));
      check({tag, ".fall"}, 32'(fall_o), 32'(m_fall));
      check({tag, ".busy"}, 32'(busy_o), 32'(m_run > 0));
      check({tag, ".glitch"}, 32'(glitch_cnt_o), 32'(m_glitch));
      check({tag, ".rf_excl"}, 32'(rise_o & fall_o), 32'd0);
   endtask

   // One clock edge: drive inputs, advance the model, sample 1 ns after the edge.
   task automatic step(input logic r, input logic c, input string tag);
      raw_i        = r;
      clr_glitch_i = c;
      @(posedge clk);
      if (reset) model_reset();
      else model_edge(r, c);
      #1;
      compare_all(tag);
   endtask

   // Asynchronous reset applied mid-cycle; outputs must clear immediately.
   task automatic do_reset(input string tag);
      reset = 1'b1;
      #1;
      model_reset();
      compare_all({tag, ".async"});
      step(raw_i, 1'b0, {tag, ".held"});
      reset = 1'b0;
   endtask

   initial begin : main
      int cnt_rise, cnt_fall, cnt_lvl;
      logic prev_lvl, tgt, v;
      reset        = 1'b1;
      raw_i        = 1'b0;
      clr_glitch_i = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      compare_all("reset");
      reset = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "idle");

      // 1: latency of a clean rising edge
      for (int e = 1; e <= 7; e++) begin
         step(1'b1, 1'b0, "t1");
         check($sformatf("t1.busy_e%0d", e), 32'(busy_o), 32'(e >= 3 && e <= 5));
         check($sformatf("t1.rise_e%0d", e), 32'(rise_o), 32'(e == 6));
         check($sformatf("t1.level_e%0d", e), 32'(level_o), 32'(e >= 6));
      end

      // 2: short high pulse is rejected and counted
      do_reset("t2r");
      cnt_rise = 0;
      for (int e = 0; e < 3; e++) begin step(1'b1, 1'b0, "t2"); cnt_rise += int'(rise_o); end
      for (int e = 0; e < 8; e++) begin step(1'b0, 1'b0, "t2"); cnt_rise += int'(rise_o); end
      check("t2.level", 32'(level_o), 32'd0);
      check("t2.rises", 32'(cnt_rise), 32'd0);
      check("t2.glitch", 32'(glitch_cnt_o), 32'd1);

      // 3: clean falling edge from a high level
      do_reset("t3r");
      for (int e = 0; e < 8; e++) step(1'b1, 1'b0, "t3h");
      check("t3.level_hi", 32'(level_o), 32'd1);
      cnt_rise = 0; cnt_fall = 0;
      for (int e = 0; e < 8; e++) begin
         step(1'b0, 1'b0, "t3l");
         cnt_rise += int'(rise_o);
         cnt_fall += int'(fall_o);
      end
      check("t3.falls", 32'(cnt_fall), 32'd1);
      check("t3.rises", 32'(cnt_rise), 32'd0);
      check("t3.level_lo", 32'(level_o), 32'd0);

      // 4: saturation after 5 aborts, then clear coincident with a glitch
      do_reset("t4r");
      for (int g = 0; g < 5; g++) begin
         for (int e = 0; e < 2; e++) step(1'b1, 1'b0, "t4h");
         for (int e = 0; e < 4; e++) step(1'b0, 1'b0, "t4l");
      end
      check("t4.sat", 32'(glitch_cnt_o), 32'd3);
      for (int e = 0; e < 2; e++) step(1'b1, 1'b0, "t4h");
      v = 1'b0;
      for (int e = 0; e < 4; e++) begin
         if (glitch_next()) v = 1'b1;
         step(1'b0, glitch_next(), "t4c");
      end
      check("t4.clr_hit", 32'(v), 32'd1);
      check("t4.cleared", 32'(glitch_cnt_o), 32'd0);

      // 5: reset during CHK_HIGH with cnt=2, then release with raw held high
      do_reset("t5r");
      for (int e = 0; e < 2; e++) step(1'b0, 1'b0, "t5i");
      for (int e = 0; e < 4; e++) step(1'b1, 1'b0, "t5q");
      check("t5.busy_pre", 32'(busy_o), 32'd1);
      do_reset("t5m");
      check("t5.glitch", 32'(glitch_cnt_o), 32'd0);
      for (int e = 1; e <= 7; e++) begin
         step(1'b1, 1'b0, "t5");
         check($sformatf("t5.rise_e%0d", e), 32'(rise_o), 32'(e == SYNC + D));
      end

      // 6: bounce bursts shorter than D, then a stable opposite level
      for (int b = 0; b < 6; b++) begin
         tgt      = !level_o;
         prev_lvl = level_o;
         cnt_lvl  = 0;
         v        = tgt;
         for (int r = 0; r < 2 + int'($urandom_range(0, 4)); r++) begin
            for (int e = 0; e < int'($urandom_range(1, D - 1)); e++) begin
               step(v, 1'b0, "t6b");
               if (level_o != prev_lvl) cnt_lvl++;
               prev_lvl = level_o;
            end
            v = !v;
         end
         for (int e = 0; e < SYNC + D + 3; e++) begin
            step(tgt, 1'b0, "t6s");
            if (level_o != prev_lvl) cnt_lvl++;
            prev_lvl = level_o;
         end
         check($sformatf("t6.edges_b%0d", b), 32'(cnt_lvl), 32'd1);
         check($sformatf("t6.level_b%0d", b), 32'(level_o), 32'(tgt));
      end

      // Free-running random input with occasional clears
      v = 1'b0;
      for (int e = 0; e < 400; e++) begin
         if ($urandom_range(0, 5) == 0) v = !v;
         step(v, ($urandom_range(0, 19) == 0), "rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
